// File: rtl/decode_stage.sv
// decode_stage: MIPS instruction-decode stage.
// Holds the register file with a same-cycle write-back bypass, a per-register
// pending-write scoreboard for RAW hazards, immediate sign extension and the
// branch-target adder. Valid/ready handshake towards IF and towards EX.
module decode_stage #(
  parameter int DATA_W = 32,
  parameter int NREGS  = 32,
  parameter int ADDR_W = 5,
  parameter int PC_W   = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_valid,
  input  logic [31:0]       if_instr,
  input  logic [PC_W-1:0]   if_pc,
  output logic              id_ready,
  input  logic              flush,
  input  logic              wb_we,
  input  logic [ADDR_W-1:0] wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  input  logic              ex_ready,
  output logic              ex_valid,
  output logic [5:0]        ex_opcode,
  output logic [DATA_W-1:0] ex_data1,
  output logic [DATA_W-1:0] ex_data2,
  output logic [DATA_W-1:0] ex_imm,
  output logic [ADDR_W-1:0] ex_rs,
  output logic [ADDR_W-1:0] ex_rt,
  output logic [ADDR_W-1:0] ex_rd,
  output logic [PC_W-1:0]   ex_branch_target,
  output logic              hazard
);

  localparam logic [5:0] OP_R    = 6'd0;
  localparam logic [5:0] OP_BEQ  = 6'd4;
  localparam logic [5:0] OP_ADDI = 6'd8;
  localparam logic [5:0] OP_LW   = 6'd35;
  localparam logic [5:0] OP_SW   = 6'd43;

  localparam logic [ADDR_W-1:0] R0       = {ADDR_W{1'b0}};
  localparam logic [NREGS-1:0]  ONE_HOT0 = {{(NREGS-1){1'b0}}, 1'b1};
  localparam logic [NREGS-1:0]  NO_BITS  = {NREGS{1'b0}};

  // Sign-extend a 16-bit immediate to the data width.
  function automatic logic [DATA_W-1:0] sext16(input logic [15:0] v);
    return {{(DATA_W-16){v[15]}}, v};
  endfunction

  logic [DATA_W-1:0] regs_r [NREGS];
  logic [NREGS-1:0]  pend_r;
  logic [NREGS-1:0]  pend_next_s;
  logic [ADDR_W-1:0] ex_dest_r;
  logic              ex_has_dest_r;

  logic [5:0]        op_s;
  logic [ADDR_W-1:0] rs_s, rt_s, rd_s, dest_s;
  logic              use_rs_s, use_rt_s, has_dest_s, imm_src_s;
  logic [DATA_W-1:0] imm_s, rs_val_s, rt_val_s;
  logic [PC_W-1:0]   imm_pc_s, target_s;
  logic              blk_rs_s, blk_rt_s, adv_s, accept_s;
  logic              wb_live_s;
  logic [NREGS-1:0]  wb_clr_s, fl_clr_s, set_s;

  assign op_s  = if_instr[31:26];
  assign rs_s  = ADDR_W'(if_instr[25:21]);
  assign rt_s  = ADDR_W'(if_instr[20:16]);
  assign rd_s  = ADDR_W'(if_instr[15:11]);
  assign imm_s = sext16(if_instr[15:0]);

  // Immediate sign-extended (or truncated) to PC width; target wraps modulo 2^PC_W.
  assign imm_pc_s = PC_W'({{PC_W{if_instr[15]}}, if_instr[15:0]});
  assign target_s = if_pc + {{(PC_W-3){1'b0}}, 3'b100} + {imm_pc_s[PC_W-3:0], 2'b00};

  // Classify the opcode: which sources are read, which register is written.
  always_comb begin
    use_rs_s   = 1'b0;
    use_rt_s   = 1'b0;
    has_dest_s = 1'b0;
    dest_s     = R0;
    imm_src_s  = 1'b0;
    case (op_s)
      OP_R: begin
        use_rs_s   = 1'b1;
        use_rt_s   = 1'b1;
        has_dest_s = 1'b1;
        dest_s     = rd_s;
      end
      OP_BEQ, OP_SW: begin
        use_rs_s = 1'b1;
        use_rt_s = 1'b1;
      end
      OP_LW, OP_ADDI: begin
        use_rs_s   = 1'b1;
        has_dest_s = 1'b1;
        dest_s     = rt_s;
        imm_src_s  = 1'b1;
      end
      default: begin
        use_rs_s = 1'b0;
      end
    endcase
  end

  assign wb_live_s = wb_we && (wb_addr != R0);

  // Operand read: r0 is hard zero, a write-back to the same index bypasses the file.
  always_comb begin
    rs_val_s = {DATA_W{1'b0}};
    rt_val_s = {DATA_W{1'b0}};
    if (rs_s == R0) begin
      rs_val_s = {DATA_W{1'b0}};
    end else if (wb_we && (wb_addr == rs_s)) begin
      rs_val_s = wb_data;
    end else begin
      rs_val_s = regs_r[rs_s];
    end
    if (rt_s == R0) begin
      rt_val_s = {DATA_W{1'b0}};
    end else if (wb_we && (wb_addr == rt_s)) begin
      rt_val_s = wb_data;
    end else begin
      rt_val_s = regs_r[rt_s];
    end
  end

  // A source waits while its write is pending, unless that write lands this cycle.
  assign blk_rs_s = use_rs_s && pend_r[rs_s] && !(wb_we && (wb_addr == rs_s));
  assign blk_rt_s = use_rt_s && pend_r[rt_s] && !(wb_we && (wb_addr == rt_s));
  assign hazard   = if_valid && (blk_rs_s || blk_rt_s);

  assign adv_s    = !ex_valid || ex_ready;
  assign id_ready = adv_s && !hazard && !flush;
  assign accept_s = if_valid && id_ready;

  // Scoreboard update: write-back and flush clear, accept sets last so it wins.
  assign wb_clr_s = wb_live_s ? (ONE_HOT0 << wb_addr) : NO_BITS;
  assign fl_clr_s = (flush && ex_valid && ex_has_dest_r) ? (ONE_HOT0 << ex_dest_r) : NO_BITS;
  assign set_s    = (accept_s && has_dest_s && (dest_s != R0)) ? (ONE_HOT0 << dest_s) : NO_BITS;
  assign pend_next_s = ((pend_r & ~wb_clr_s & ~fl_clr_s) | set_s) & ~ONE_HOT0;

  // Pending-write scoreboard register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pend_r <= NO_BITS;
    end else begin
      pend_r <= pend_next_s;
    end
  end

  // Register file; writes to r0 are dropped.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) begin
        regs_r[i] <= {DATA_W{1'b0}};
      end
    end else if (wb_live_s) begin
      regs_r[wb_addr] <= wb_data;
    end
  end

  // EX register: load on accept, bubble when advancing empty, hold while EX stalls.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ex_valid         <= 1'b0;
      ex_opcode        <= 6'd0;
      ex_data1         <= {DATA_W{1'b0}};
      ex_data2         <= {DATA_W{1'b0}};
      ex_imm           <= {DATA_W{1'b0}};
      ex_rs            <= R0;
      ex_rt            <= R0;
      ex_rd            <= R0;
      ex_branch_target <= {PC_W{1'b0}};
      ex_dest_r        <= R0;
      ex_has_dest_r    <= 1'b0;
    end else if (flush) begin
      ex_valid <= 1'b0;
    end else if (accept_s) begin
      ex_valid         <= 1'b1;
      ex_opcode        <= op_s;
      ex_data1         <= rs_val_s;
      ex_data2         <= imm_src_s ? imm_s : rt_val_s;
      ex_imm           <= imm_s;
      ex_rs            <= rs_s;
      ex_rt            <= rt_s;
      ex_rd            <= rd_s;
      ex_branch_target <= target_s;
      ex_dest_r        <= dest_s;
      ex_has_dest_r    <= has_dest_s && (dest_s != R0);
    end else if (adv_s) begin
      ex_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_decode_stage.sv
// Directed testbench for decode_stage with hand-computed expectations.
module tb_decode_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic        id_ready;
  logic        flush;
  logic        wb_we;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        ex_ready;
  logic        ex_valid;
  logic [5:0]  ex_opcode;
  logic [31:0] ex_data1, ex_data2, ex_imm;
  logic [4:0]  ex_rs, ex_rt, ex_rd;
  logic [31:0] ex_branch_target;
  logic        hazard;

  int tests_run    = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  decode_stage #(.DATA_W(32), .NREGS(32), .ADDR_W(5), .PC_W(32)) dut (
    .clk(clk), .reset(reset),
    .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc), .id_ready(id_ready),
    .flush(flush), .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data),
    .ex_ready(ex_ready), .ex_valid(ex_valid), .ex_opcode(ex_opcode),
    .ex_data1(ex_data1), .ex_data2(ex_data2), .ex_imm(ex_imm),
    .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd),
    .ex_branch_target(ex_branch_target), .hazard(hazard)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] r_type(input logic [4:0] rs, input logic [4:0] rt,
                                         input logic [4:0] rd);
    return {6'd0, rs, rt, rd, 5'd0, 6'h20};
  endfunction

  function automatic logic [31:0] i_type(input logic [5:0] op, input logic [4:0] rs,
                                         input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  // Advance one clock; sample 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; if_valid = 1'b0; if_instr = 32'd0; if_pc = 32'd0; flush = 1'b0;
    wb_we = 1'b0; wb_addr = 5'd0; wb_data = 32'd0; ex_ready = 1'b1;
    tick(); tick();
    reset = 1'b0;
    #1;
    check("rst_ex_valid", 32'(ex_valid), 32'd0);
    check("rst_data1", ex_data1, 32'd0);
    check("rst_target", ex_branch_target, 32'd0);
    check("rst_id_ready", 32'(id_ready), 32'd1);
    check("rst_hazard", 32'(hazard), 32'd0);

    // 1: write r5, then add r3,r5,r0
    wb_we = 1'b1; wb_addr = 5'd5; wb_data = 32'h1234;
    tick();
    wb_we = 1'b0;
    if_valid = 1'b1; if_instr = r_type(5'd5, 5'd0, 5'd3); if_pc = 32'h40;
    #1 check("t1_id_ready", 32'(id_ready), 32'd1);
    tick();
    if_valid = 1'b0;
    check("t1_ex_valid", 32'(ex_valid), 32'd1);
    check("t1_data1", ex_data1, 32'h1234);
    check("t1_data2", ex_data2, 32'd0);
    check("t1_rd", 32'(ex_rd), 32'd3);

    // 2: lw r2,8(r1) then add r4,r2,r2 stalls until wb r2 (bypass)
    if_valid = 1'b1; if_instr = i_type(6'd35, 5'd1, 5'd2, 16'd8);
    tick();
    check("t2_lw_data2", ex_data2, 32'd8);
    check("t2_lw_rt", 32'(ex_rt), 32'd2);
    if_instr = r_type(5'd2, 5'd2, 5'd4);
    #1;
    check("t2_hazard", 32'(hazard), 32'd1);
    check("t2_id_ready", 32'(id_ready), 32'd0);
    tick();
    check("t2_bubble", 32'(ex_valid), 32'd0);
    check("t2_hazard_hold", 32'(hazard), 32'd1);
    wb_we = 1'b1; wb_addr = 5'd2; wb_data = 32'h55;
    #1;
    check("t2_hazard_wb", 32'(hazard), 32'd0);
    check("t2_id_ready_wb", 32'(id_ready), 32'd1);
    tick();
    wb_we = 1'b0; if_valid = 1'b0;
    check("t2_ex_valid", 32'(ex_valid), 32'd1);
    check("t2_data1", ex_data1, 32'h55);
    check("t2_data2", ex_data2, 32'h55);
    check("t2_rd", 32'(ex_rd), 32'd4);

    // 3: EX stalls three cycles, entry holds; release issues add r6,r5,r5
    ex_ready = 1'b0;
    if_valid = 1'b1; if_instr = r_type(5'd5, 5'd5, 5'd6);
    for (int i = 0; i < 3; i++) begin
      #1 check("t3_id_ready_stall", 32'(id_ready), 32'd0);
      tick();
      check("t3_hold_valid", 32'(ex_valid), 32'd1);
      check("t3_hold_rd", 32'(ex_rd), 32'd4);
      check("t3_hold_data1", ex_data1, 32'h55);
    end
    ex_ready = 1'b1;
    #1 check("t3_id_ready_rel", 32'(id_ready), 32'd1);
    tick();
    check("t3_next_rd", 32'(ex_rd), 32'd6);
    check("t3_next_data1", ex_data1, 32'h1234);

    // 4: branch targets and immediate sign extension
    if_instr = i_type(6'd4, 5'd0, 5'd0, 16'hFFFF); if_pc = 32'h100;
    tick();
    check("t4_target_m1", ex_branch_target, 32'h100);
    check("t4_imm_m1", ex_imm, 32'hFFFF_FFFF);
    if_instr = i_type(6'd4, 5'd0, 5'd0, 16'h0003);
    tick();
    check("t4_target_p3", ex_branch_target, 32'h110);
    if_instr = i_type(6'd8, 5'd0, 5'd9, 16'h8000);
    tick();
    check("t4_addi_imm", ex_imm, 32'hFFFF_8000);
    check("t4_addi_data2", ex_data2, 32'hFFFF_8000);

    // 5: addi r7 killed by flush clears its pending bit
    if_instr = i_type(6'd8, 5'd0, 5'd7, 16'h0001);
    tick();
    if_valid = 1'b0; flush = 1'b1;
    #1 check("t5_id_ready_flush", 32'(id_ready), 32'd0);
    tick();
    flush = 1'b0;
    check("t5_flushed", 32'(ex_valid), 32'd0);
    if_valid = 1'b1; if_instr = r_type(5'd7, 5'd7, 5'd10);
    #1;
    check("t5_no_hazard", 32'(hazard), 32'd0);
    check("t5_id_ready", 32'(id_ready), 32'd1);
    tick();
    check("t5_issued", 32'(ex_valid), 32'd1);
    check("t5_rs", 32'(ex_rs), 32'd7);
    check("t5_data1", ex_data1, 32'd0);

    // 6: r0 is never written, bypassed or pending
    wb_we = 1'b1; wb_addr = 5'd0; wb_data = 32'hFF;
    if_instr = r_type(5'd0, 5'd0, 5'd11);
    tick();
    wb_we = 1'b0;
    check("t6_r0_bypass_d1", ex_data1, 32'd0);
    check("t6_r0_bypass_d2", ex_data2, 32'd0);
    if_instr = r_type(5'd0, 5'd0, 5'd12);
    tick();
    check("t6_r0_file", ex_data1, 32'd0);
    if_instr = i_type(6'd8, 5'd0, 5'd0, 16'h0005);
    tick();
    if_instr = r_type(5'd0, 5'd0, 5'd13);
    #1;
    check("t6_r0_no_hazard", 32'(hazard), 32'd0);
    check("t6_r0_id_ready", 32'(id_ready), 32'd1);
    tick();
    check("t6_r0_reader_rd", 32'(ex_rd), 32'd13);

    // Reset mid-operation: EX entry, register file and scoreboard all cleared
    reset = 1'b1;
    #1 check("mid_rst_ex_valid", 32'(ex_valid), 32'd0);
    tick();
    reset = 1'b0;
    if_valid = 1'b1; if_instr = r_type(5'd5, 5'd6, 5'd14);
    #1 check("mid_rst_no_hazard", 32'(hazard), 32'd0);
    tick();
    if_valid = 1'b0;
    check("mid_rst_valid", 32'(ex_valid), 32'd1);
    check("mid_rst_r5", ex_data1, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
